mult_share_sched: RTL

Round-robin scheduler that shares one combinational 8x8 signed multiplier datapath among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the operands to the shared multiplier from a register stage. It then captures the 16-bit product in a result stage and returns it with the requester ID on a single valid/ready response channel. It sits between the MAC/filter front-ends and the approximate radix-8/radix-4 Booth multiplier instance, so either an exact or an approximate multiplier can be hung off the same ports.

---
 rtl/mult_sched_pkg.sv | 27 ++
 rtl/mult_share_sched_rr_arbiter.sv | 61 ++++++
 rtl/mult_share_sched.sv | 99 +++++++++
 3 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg
//   Shared widths and pipeline-stage record types for the shared-multiplier
//   scheduler. The ID fields are sized for the largest supported requester
//   count. The top level narrows them to its own ID width.
package mult_sched_pkg;

  localparam int OP_W     = 8;
  localparam int PROD_W   = 16;
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = $clog2(MAX_REQ);

  // ISSUE stage: operands currently presented to the shared multiplier
  typedef struct packed {
    logic                     vld;
    logic [MAX_ID_W-1:0]      id;
    logic signed [OP_W-1:0]   a;
    logic signed [OP_W-1:0]   b;
  } iss_t;

  // RESULT stage: captured product waiting for the response consumer
  typedef struct packed {
    logic                     vld;
    logic [MAX_ID_W-1:0]      id;
    logic signed [PROD_W-1:0] z;
  } res_t;

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. It grants the first asserted request at or above the
//   pointer, wrapping around. The pointer moves past the winner only when a
//   grant is issued.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req     [N]  : request vector
//   i_en           : grant permitted this cycle
//   o_gnt     [N]  : one-hot grant (zero when disabled or idle)
//   o_gnt_idx      : binary index of the granted requester
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_rot;
  logic [N-1:0]     w_pick;
  logic [N-1:0]     w_gnt;

  // Rotate the requests so that the pointer position lands at bit 0. A plain
  // lowest-set-bit priority pick then gives the round-robin winner.
  assign w_rot = N'({i_req, i_req} >> r_ptr);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pick
      if (gi == 0) begin : g_first
        assign w_pick[gi] = w_rot[gi];
      end else begin : g_rest
        assign w_pick[gi] = w_rot[gi] & ~(|w_rot[gi-1:0]);
      end
    end
  endgenerate

  // Rotate the pick back into requester order (upper half of the doubled vector)
  assign w_gnt = i_en ? N'(({w_pick, w_pick} << r_ptr) >> N) : '0;
  assign o_gnt = w_gnt;

  always_comb begin
    o_gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gnt[k]) o_gnt_idx = o_gnt_idx | IDX_W'(k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (|w_gnt) begin
      r_ptr <= (o_gnt_idx == IDX_W'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched
//   Shares one external combinational 8x8 signed multiplier among NUM_REQ
//   requesters. The design is a two-stage pipeline. ISSUE registers the granted
//   operands and drives the multiplier. RESULT captures the product and returns
//   it together with the requester ID.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_req_valid/a/b       : per-requester operand handshake and data
//   o_req_ready           : one-hot grant (transfer on valid & ready)
//   o_mul_a, o_mul_b      : registered operands to the shared multiplier
//   i_mul_z               : product returned by the multiplier
//   o_rsp_valid/id/z      : response channel, i_rsp_ready is its ready
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ-1:0][OP_W-1:0]     i_req_a,
  input  logic [NUM_REQ-1:0][OP_W-1:0]     i_req_b,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic signed [OP_W-1:0]           o_mul_a,
  output logic signed [OP_W-1:0]           o_mul_b,
  input  logic signed [PROD_W-1:0]         i_mul_z,
  output logic                             o_rsp_valid,
  output logic [ID_W-1:0]                  o_rsp_id,
  output logic signed [PROD_W-1:0]         o_rsp_z,
  input  logic                             i_rsp_ready
);

  iss_t               r_iss;
  res_t               r_res;

  logic               w_rsp_pop;
  logic               w_res_free;
  logic               w_iss_adv;
  logic               w_iss_free;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;

  // The free signals chain back from the consumer. This lets a pop, an
  // advance and a new grant all happen in one cycle with no bubble.
  assign w_rsp_pop  = r_res.vld & i_rsp_ready;
  assign w_res_free = ~r_res.vld | w_rsp_pop;
  assign w_iss_adv  = r_iss.vld & w_res_free;
  assign w_iss_free = ~r_iss.vld | w_iss_adv;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req_valid),
    .i_en      (w_iss_free),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign o_req_ready = w_gnt;

  // ISSUE: the operands keep their last value when the stage empties, so the
  // multiplier inputs do not toggle while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iss <= '0;
    end else if (|w_gnt) begin
      r_iss.vld <= 1'b1;
      r_iss.id  <= MAX_ID_W'(w_gnt_idx);
      r_iss.a   <= i_req_a[w_gnt_idx];
      r_iss.b   <= i_req_b[w_gnt_idx];
    end else if (w_iss_adv) begin
      r_iss.vld <= 1'b0;
    end
  end

  // RESULT: id/z are loaded only on advance, so they stay stable under backpressure
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res <= '0;
    end else if (w_iss_adv) begin
      r_res.vld <= 1'b1;
      r_res.id  <= r_iss.id;
      r_res.z   <= i_mul_z;
    end else if (w_rsp_pop) begin
      r_res.vld <= 1'b0;
    end
  end

  assign o_mul_a     = r_iss.a;
  assign o_mul_b     = r_iss.b;
  assign o_rsp_valid = r_res.vld;
  assign o_rsp_id    = ID_W'(r_res.id);
  assign o_rsp_z     = r_res.z;

endmodule
